ai_paddle_ctrl: RTL and testbench
=================================

// Module: ai_paddle_ctrl
// PURPOSE
//  Computer opponent for the left side. Upstream of the physics step: drives its AI_M move code.
//  On each stclk frame tick it snapshots ball and left-paddle state and scans the 5 balls, one per cycle.
//  It picks the most threatening ball and registers one move code, which step applies at the next stclk.
// PARAMETERS
//  NBALL     5    balls scanned (index 0..NBALL-1)
//  DEADBAND  6    |target_y - paddle_y| <= DEADBAND -> no move
//  LOOKAHEAD 4    frames of y extrapolation (AI_PREDICT_EN only)
// PORTS
//  clk        in   1     system clock
//  rst_n      in   1     async reset, active-low
//  stclk      in   1     frame tick, 1-cycle pulse
//  aim        in   1     AI enabled; 0 -> AI_M forced 0, FSM idles
//  ball_posx  in   55    packed signed 11b x of balls, ball i at [11i+10:11i]
//  ball_posy  in   55    packed signed 11b y
//  ball_velx  in   55    packed signed 11b x velocity
//  ball_vely  in   55    packed signed 11b y velocity
//  pad0_posx  in   11    paddle10 x (outer); pad0_posy in 11 paddle10 y
//  pad1_posx  in   11    paddle11 x (inner); pad1_posy in 11 paddle11 y
//  AI_M       out  3     move code: 0 none, 1 pad0 +y, 2 pad0 -y, 3 pad1 +y, 4 pad1 -y
//  ai_busy    out  1     scan in progress
//  ai_valid   out  1     1-cycle pulse when AI_M updates
// BEHAVIOUR
//  Reset: AI_M=0, ai_busy=0, ai_valid=0, state IDLE, threat regs cleared.
//  FSM IDLE -> SNAP (stclk & aim) -> SCAN (NBALL cycles, idx 0..4) -> DECIDE -> IDLE.
//  Timing: stclk in cycle 0; SNAP in cycle 1; SCAN in cycles 2..6; DECIDE in cycle 7.
//   AI_M and the ai_valid pulse appear in cycle 8. ai_busy=1 in cycles 1..7.
//  step consumes AI_M at the same stclk that starts the next scan: one-frame decision lag.
//  SNAP: latches all ball/paddle inputs; the scan uses only the snapshot.
//  SCAN, ball i is a threat iff velx<0 and posx>BALL_RADIUS.
//   Keep the threat with the smallest posx; on a tie the lower index wins.
//  DECIDE, target paddle:
//   - threat posx >= pad1_posx+PAD_WIDTH -> pad1; else pad0.
//   - no threat: pad1 with target_y=HEIGHT/2.
//  DECIDE, target_y = threat posy. Let d = target_y - pad_y (signed 12b).
//   - d > DEADBAND and pad_y < HEIGHT-HALF_PAD_HEIGHT -> +y code (1 or 3).
//   - d < -DEADBAND and pad_y > HALF_PAD_HEIGHT -> -y code (2 or 4).
//   - otherwise AI_M=0.
//  stclk during SNAP/SCAN/DECIDE: abort, restart at SNAP. AI_M keeps its old value; no ai_valid.
//  aim=0: AI_M=0 next cycle and the FSM returns to IDLE. aim rising: first decision after the next stclk.
//  Reset mid-scan: immediate return to reset values.
//  All compares are signed. Every intermediate is widened to 12b, so no overflow.
// CONFIGURATION
//  AI_PREDICT_EN defined: target_y = posy + vely*LOOKAHEAD in 14b signed.
//   Clamped to [BALL_RADIUS, HEIGHT-BALL_RADIUS]. Adds one pipeline cycle: DECIDE in cycle 8, AI_M in cycle 9.
//  AI_PREDICT_EN undefined: target_y = posy, timing as above.
// STRUCTURE
//  Shared header game_params.vh: WIDTH=640, HEIGHT=480, BALL_RADIUS=6, PAD_WIDTH=4.
//   Also PAD_HEIGHT=80, HALF_PAD_HEIGHT=40, and move-code localparams MV_NONE..MV_P1_DN.
//   The physics step uses the same header.
//  Sub-module ai_target_select: the per-cycle compare/keep-min threat register with its valid flag.
//  Top holds the FSM, snapshot, DECIDE logic and predict option.
// TESTING
//  1. aim=1, one threat ball (x=200,y=400,vx=-2), others vx>0, pad1 y=240; stclk.
//     -> AI_M=3 and ai_valid in cycle 8.
//  2. Two threats, x=150 and x=150 at idx 1 and 3; ball1 y=100, pad1 y=240.
//     -> idx1 chosen, AI_M=4.
//  3. Threat x=30 (behind pad1 at x=61), y=240, pad0 y=240. -> pad0 selected, |d|<=6 -> AI_M=0.
//  4. No threats, pad1 y=440. -> AI_M=4.
//     Repeat with pad1 y=40 and target 240 -> AI_M=3.
//     Edge guard: target 479, pad1 y=440 -> AI_M=0.
//  5. Second stclk in cycle 4 of a scan. -> no ai_valid at cycle 8.
//     Restart: valid 8 cycles after the 2nd stclk. rst_n low mid-scan -> AI_M=0, ai_busy=0 at once.
//  6. AI_PREDICT_EN: y=470, vy=+3, LOOKAHEAD=4.
//     -> target clamps to 474, AI_M=3 for pad1 y=240, latency 9.
//     aim=0 at any time -> AI_M=0 next cycle.

Source files
------------

// File: rtl/ai_paddle_ctrl_pkg.sv
// Shared game geometry, move codes and AI FSM types for the left-side computer opponent.
package ai_paddle_ctrl_pkg;
  localparam int WIDTH           = 640;
  localparam int HEIGHT          = 480;
  localparam int BALL_RADIUS     = 6;
  localparam int PAD_WIDTH       = 4;
  localparam int PAD_HEIGHT      = 80;
  localparam int HALF_PAD_HEIGHT = 40;

  localparam logic [2:0] MV_NONE  = 3'd0;
  localparam logic [2:0] MV_P0_UP = 3'd1;
  localparam logic [2:0] MV_P0_DN = 3'd2;
  localparam logic [2:0] MV_P1_UP = 3'd3;
  localparam logic [2:0] MV_P1_DN = 3'd4;

  typedef enum logic [2:0] {ST_IDLE, ST_SNAP, ST_SCAN, ST_PRED, ST_DECIDE} ai_state_e;

  typedef struct packed {
    logic               valid;
    logic [2:0]         idx;
    logic signed [10:0] posx;
  } threat_t;

  function automatic logic signed [11:0] sx12(input logic [10:0] v);
    return $signed({v[10], v});
  endfunction
endpackage

// File: rtl/ai_paddle_ctrl_target_select.sv
// Keep-min threat register: one ball per cycle, remembers the closest incoming ball.
module ai_target_select
  import ai_paddle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [2:0]         i_idx,
  input  logic signed [10:0] i_posx,
  input  logic               i_vxneg,
  output threat_t            o_thr
);
  localparam logic signed [10:0] C_BR = 11'(BALL_RADIUS);

  threat_t r_thr;
  logic    w_threat;

  assign w_threat = i_vxneg && (i_posx > C_BR);
  assign o_thr    = r_thr;

  // Strict less-than: scan runs in ascending index, so ties keep the lower index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr <= '0;
    end else if (i_clr) begin
      r_thr <= '0;
    end else if (i_en && w_threat && (!r_thr.valid || i_posx < r_thr.posx)) begin
      r_thr.valid <= 1'b1;
      r_thr.idx   <= i_idx;
      r_thr.posx  <= i_posx;
    end
  end
endmodule

// File: rtl/ai_paddle_ctrl.sv
// Left-side AI: snapshot on stclk, scan balls, pick a paddle and register a move code.
// Optional AI_PREDICT_EN: extrapolate target y by LOOKAHEAD frames (adds one cycle).
module ai_paddle_ctrl
  import ai_paddle_ctrl_pkg::*;
#(
  parameter int NBALL     = 5,
  parameter int DEADBAND  = 6,
  parameter int LOOKAHEAD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stclk,
  input  logic                  aim,
  input  logic [NBALL*11-1:0]   ball_posx,
  input  logic [NBALL*11-1:0]   ball_posy,
  input  logic [NBALL*11-1:0]   ball_velx,
  input  logic [NBALL*11-1:0]   ball_vely,
  input  logic [10:0]           pad0_posx,
  input  logic [10:0]           pad0_posy,
  input  logic [10:0]           pad1_posx,
  input  logic [10:0]           pad1_posy,
  output logic [2:0]            AI_M,
  output logic                  ai_busy,
  output logic                  ai_valid
);
  localparam logic signed [11:0] C_PW   = 12'(PAD_WIDTH);
  localparam logic signed [11:0] C_DB   = 12'(DEADBAND);
  localparam logic signed [11:0] C_NDB  = -C_DB;
  localparam logic signed [11:0] C_YTOP = 12'(HEIGHT - HALF_PAD_HEIGHT);
  localparam logic signed [11:0] C_HPH  = 12'(HALF_PAD_HEIGHT);
  localparam logic signed [11:0] C_MID  = 12'(HEIGHT / 2);

  ai_state_e                r_state;
  logic [2:0]               r_idx;
  logic [2:0]               r_move;
  logic                     r_busy, r_valid;
  logic [NBALL-1:0][10:0]   r_px, r_py;
  logic [NBALL-1:0]         r_vxneg;
  logic [10:0]              r_p0y, r_p1x, r_p1y;

  threat_t                  w_thr;
  logic signed [11:0]       w_tgt_raw, w_tgt, w_pad_y, w_d;
  logic                     w_use_p1;
  logic [2:0]               w_move;
  logic                     w_unused;

  ai_target_select u_sel (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state == ST_SNAP),
    .i_en    (r_state == ST_SCAN),
    .i_idx   (r_idx),
    .i_posx  ($signed(r_px[r_idx])),
    .i_vxneg (r_vxneg[r_idx]),
    .o_thr   (w_thr)
  );

`ifdef AI_PREDICT_EN
  localparam logic signed [13:0] C_LA   = 14'(LOOKAHEAD);
  localparam logic signed [13:0] C_YMIN = 14'(BALL_RADIUS);
  localparam logic signed [13:0] C_YMAX = 14'(HEIGHT - BALL_RADIUS);

  logic [NBALL-1:0][10:0] r_vy;
  logic signed [11:0]     r_tgt;
  logic signed [13:0]     w_py14, w_vy14, w_pred;

  assign w_py14 = $signed({{3{r_py[w_thr.idx][10]}}, r_py[w_thr.idx]});
  assign w_vy14 = $signed({{3{r_vy[w_thr.idx][10]}}, r_vy[w_thr.idx]});
  assign w_pred = w_py14 + w_vy14 * C_LA;

  always_comb begin
    w_tgt_raw = C_MID;
    if (w_thr.valid) begin
      if (w_pred < C_YMIN)      w_tgt_raw = C_YMIN[11:0];
      else if (w_pred > C_YMAX) w_tgt_raw = C_YMAX[11:0];
      else                      w_tgt_raw = w_pred[11:0];
    end
  end

  // Predicted target is registered in ST_PRED to keep the multiply off the decide path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vy  <= '0;
      r_tgt <= '0;
    end else begin
      if (r_state == ST_SNAP) r_vy  <= ball_vely;
      if (r_state == ST_PRED) r_tgt <= w_tgt_raw;
    end
  end

  assign w_tgt    = r_tgt;
  assign w_unused = ^{pad0_posx, ball_velx};
`else
  assign w_tgt_raw = w_thr.valid ? sx12(r_py[w_thr.idx]) : C_MID;
  assign w_tgt     = w_tgt_raw;
  assign w_unused  = ^{pad0_posx, ball_velx, ball_vely};
`endif

  assign w_use_p1 = !w_thr.valid || (sx12(w_thr.posx) >= sx12(r_p1x) + C_PW);
  assign w_pad_y  = w_use_p1 ? sx12(r_p1y) : sx12(r_p0y);
  assign w_d      = w_tgt - w_pad_y;

  always_comb begin
    w_move = MV_NONE;
    if (w_d > C_DB && w_pad_y < C_YTOP)
      w_move = w_use_p1 ? MV_P1_UP : MV_P0_UP;
    else if (w_d < C_NDB && w_pad_y > C_HPH)
      w_move = w_use_p1 ? MV_P1_DN : MV_P0_DN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_move  <= MV_NONE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
      r_vxneg <= '0;
      r_p0y   <= '0;
      r_p1x   <= '0;
      r_p1y   <= '0;
    end else if (!aim) begin
      r_state <= ST_IDLE;
      r_move  <= MV_NONE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // A frame tick always (re)starts the scan; an in-flight decision is dropped.
      if (stclk) begin
        r_state <= ST_SNAP;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_SNAP: begin
            r_px  <= ball_posx;
            r_py  <= ball_posy;
            for (int i = 0; i < NBALL; i++) r_vxneg[i] <= ball_velx[11*i+10];
            r_p0y <= pad0_posy;
            r_p1x <= pad1_posx;
            r_p1y <= pad1_posy;
            r_idx <= '0;
            r_state <= ST_SCAN;
          end
          ST_SCAN: begin
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'(NBALL - 1))
`ifdef AI_PREDICT_EN
              r_state <= ST_PRED;
`else
              r_state <= ST_DECIDE;
`endif
          end
          ST_PRED:   r_state <= ST_DECIDE;
          ST_DECIDE: begin
            r_move  <= w_move;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign AI_M     = r_move;
  assign ai_busy  = r_busy;
  assign ai_valid = r_valid;
endmodule

// File: tb/tb_ai_paddle_ctrl.sv
// Directed table-driven bench for ai_paddle_ctrl plus abort / aim / reset sequences.
module tb_ai_paddle_ctrl;
`ifdef AI_PREDICT_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  typedef struct {
    string            name;
    logic [4:0][10:0] bx, by, bvx, bvy;
    logic [10:0]      p0x, p0y, p1x, p1y;
    logic [2:0]       exp;
  } vec_t;

  logic        clk = 0, rst_n = 0, stclk = 0, aim = 0;
  logic [54:0] ball_posx = '0, ball_posy = '0, ball_velx = '0, ball_vely = '0;
  logic [10:0] pad0_posx = '0, pad0_posy = '0, pad1_posx = '0, pad1_posy = '0;
  logic [2:0]  AI_M;
  logic        ai_busy, ai_valid;

  int n_cmp = 0, n_bad = 0;
  vec_t tv[$];

  ai_paddle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stclk(stclk), .aim(aim),
    .ball_posx(ball_posx), .ball_posy(ball_posy), .ball_velx(ball_velx), .ball_vely(ball_vely),
    .pad0_posx(pad0_posx), .pad0_posy(pad0_posy), .pad1_posx(pad1_posx), .pad1_posy(pad1_posy),
    .AI_M(AI_M), .ai_busy(ai_busy), .ai_valid(ai_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string n, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, expv);
    end
  endtask

  function automatic vec_t base(input string n);
    vec_t v;
    v.name = n;
    for (int i = 0; i < 5; i++) begin
      v.bx[i] = 11'd300; v.by[i] = 11'd100; v.bvx[i] = 11'd2; v.bvy[i] = 11'd0;
    end
    v.p0x = 11'd20; v.p0y = 11'd240; v.p1x = 11'd61; v.p1y = 11'd240;
    v.exp = 3'd0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    ball_posx = v.bx; ball_posy = v.by; ball_velx = v.bvx; ball_vely = v.bvy;
    pad0_posx = v.p0x; pad0_posy = v.p0y; pad1_posx = v.p1x; pad1_posy = v.p1y;
  endtask

  // One full frame: stclk in cycle 0, busy through LAT-1, result in cycle LAT.
  task automatic run_vec(input vec_t v);
    int bad_busy, early;
    apply(v);
    tick(); stclk = 1;
    tick(); stclk = 0;
    bad_busy = 0; early = 0;
    for (int c = 1; c < LAT; c++) begin
      if (!ai_busy) bad_busy++;
      if (ai_valid) early++;
      tick();
    end
    chk({v.name, "_busy_window"}, bad_busy, 0);
    chk({v.name, "_early_valid"}, early, 0);
    chk({v.name, "_valid"}, int'(ai_valid), 1);
    chk({v.name, "_AI_M"}, int'(AI_M), int'(v.exp));
    chk({v.name, "_busy_done"}, int'(ai_busy), 0);
    tick();
    chk({v.name, "_valid_pulse"}, int'(ai_valid), 0);
  endtask

  initial begin
    vec_t v, v1, v2;
    int seen, moved;

    v = base("one_threat"); v.bx[2] = 11'd200; v.by[2] = 11'd400; v.bvx[2] = 11'(-2); v.exp = 3'd3; tv.push_back(v);
    v1 = v;
    v = base("tie_low_idx"); v.bx[1] = 11'd150; v.by[1] = 11'd100; v.bvx[1] = 11'(-1);
    v.bx[3] = 11'd150; v.by[3] = 11'd400; v.bvx[3] = 11'(-1); v.exp = 3'd4; tv.push_back(v);
    v2 = v;
    v = base("behind_pad1"); v.bx[0] = 11'd30; v.by[0] = 11'd240; v.bvx[0] = 11'(-3); v.p1y = 11'd100; v.exp = 3'd0; tv.push_back(v);
    v = base("none_down"); v.p1y = 11'd440; v.exp = 3'd4; tv.push_back(v);
    v = base("none_up"); v.p1y = 11'd40; v.exp = 3'd3; tv.push_back(v);
    v = base("top_guard"); v.bx[4] = 11'd200; v.by[4] = 11'd479; v.bvx[4] = 11'(-1); v.p1y = 11'd440; v.exp = 3'd0; tv.push_back(v);
    v = base("bot_guard"); v.bx[4] = 11'd200; v.by[4] = 11'd0; v.bvx[4] = 11'(-1); v.p1y = 11'd40; v.exp = 3'd0; tv.push_back(v);
    v = base("x_eq_radius"); v.bx[0] = 11'd6; v.by[0] = 11'd440; v.bvx[0] = 11'(-1); v.p0y = 11'd440; v.p1y = 11'd440; v.exp = 3'd4; tv.push_back(v);
    v = base("x_neg"); v.bx[0] = 11'(-5); v.by[0] = 11'd440; v.bvx[0] = 11'(-1); v.p0y = 11'd440; v.p1y = 11'd440; v.exp = 3'd4; tv.push_back(v);
    v = base("x_radius_p1"); v.bx[0] = 11'd7; v.by[0] = 11'd440; v.bvx[0] = 11'(-1); v.p0y = 11'd440; v.p1y = 11'd440; v.exp = 3'd0; tv.push_back(v);
    v = base("closest_wins"); v.bx[0] = 11'd300; v.by[0] = 11'd100; v.bvx[0] = 11'(-1);
    v.bx[4] = 11'd100; v.by[4] = 11'd400; v.bvx[4] = 11'(-1); v.exp = 3'd3; tv.push_back(v);
    v = base("pad1_edge"); v.bx[2] = 11'd65; v.by[2] = 11'd400; v.bvx[2] = 11'(-1); v.p0y = 11'd400; v.exp = 3'd3; tv.push_back(v);
    v = base("pad0_edge"); v.bx[2] = 11'd64; v.by[2] = 11'd100; v.bvx[2] = 11'(-1); v.p0y = 11'd240; v.p1y = 11'd100; v.exp = 3'd2; tv.push_back(v);
    v = base("db_in"); v.bx[1] = 11'd200; v.by[1] = 11'd246; v.bvx[1] = 11'(-1); v.exp = 3'd0; tv.push_back(v);
    v = base("db_out_up"); v.bx[1] = 11'd200; v.by[1] = 11'd247; v.bvx[1] = 11'(-1); v.exp = 3'd3; tv.push_back(v);
    v = base("db_out_dn"); v.bx[1] = 11'd200; v.by[1] = 11'd233; v.bvx[1] = 11'(-1); v.exp = 3'd4; tv.push_back(v);
    v = base("vx_zero"); v.bx[1] = 11'd200; v.by[1] = 11'd100; v.bvx[1] = 11'd0; v.p1y = 11'd440; v.exp = 3'd4; tv.push_back(v);
`ifdef AI_PREDICT_EN
    v = base("pred_clamp"); v.bx[0] = 11'd200; v.by[0] = 11'd470; v.bvx[0] = 11'(-1); v.bvy[0] = 11'd3; v.exp = 3'd3; tv.push_back(v);
    v = base("pred_move"); v.bx[0] = 11'd200; v.by[0] = 11'd240; v.bvx[0] = 11'(-1); v.bvy[0] = 11'd5; v.exp = 3'd3; tv.push_back(v);
    v = base("pred_neg"); v.bx[0] = 11'd200; v.by[0] = 11'd10; v.bvx[0] = 11'(-1); v.bvy[0] = 11'(-20); v.p1y = 11'd100; v.exp = 3'd4; tv.push_back(v);
`endif

    // Reset state
    #2;
    chk("rst_AI_M", int'(AI_M), 0);
    chk("rst_busy", int'(ai_busy), 0);
    chk("rst_valid", int'(ai_valid), 0);
    tick(); rst_n = 1; aim = 1;
    tick();

    foreach (tv[i]) run_vec(tv[i]);

    // Abort: second stclk in cycle 4 drops the first scan and restarts.
    run_vec(v1);
    apply(v2);
    tick(); stclk = 1;
    tick(); stclk = 0;
    tick(); tick(); tick();
    stclk = 1;
    tick(); stclk = 0;
    seen = 0; moved = 0;
    for (int c = 1; c < LAT; c++) begin
      if (ai_valid) seen++;
      if (AI_M != 3'd3) moved++;
      tick();
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_hold_AI_M", moved, 0);
    chk("abort_restart_valid", int'(ai_valid), 1);
    chk("abort_restart_AI_M", int'(AI_M), 4);

    // aim drop mid-scan forces AI_M to 0 on the next cycle.
    run_vec(v1);
    tick(); stclk = 1;
    tick(); stclk = 0;
    tick(); tick();
    aim = 0;
    tick();
    chk("aim0_AI_M", int'(AI_M), 0);
    chk("aim0_busy", int'(ai_busy), 0);
    aim = 1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (ai_valid || ai_busy) seen++;
      tick();
    end
    chk("aim_rise_idle", seen, 0);
    run_vec(v2);

    // Asynchronous reset in the middle of a scan.
    tick(); stclk = 1;
    tick(); stclk = 0;
    tick(); tick();
    rst_n = 0;
    #1;
    chk("midrst_AI_M", int'(AI_M), 0);
    chk("midrst_busy", int'(ai_busy), 0);
    tick(); tick();
    chk("midrst_hold_valid", int'(ai_valid), 0);
    rst_n = 1;
    tick();
    run_vec(v1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
